// File: rtl/rx_iq_fifo.sv
// rx_iq_fifo: jitter buffer between the DDC output and the STM32 nibble-bus
// RX-IQ read path. Each RD_REQ pops the oldest unread {Q,I} pair, and the pair
// is presented one cycle later with a one-cycle OUT_VALID pulse. Reads are only
// served once the buffer has primed to PRIME_LEVEL entries. Priming is needed
// after reset, and again after any read that finds the buffer empty.
//
// Optional feature macro: RX_FIFO_OVERWRITE_EN. When it is defined, a write to
// a full buffer with no pop in the same cycle evicts the oldest entry. When it
// is undefined, that write is dropped.
//
// Ports:
//   clk_in, reset_in     clock, async active-high reset
//   I_IN, Q_IN, IQ_VALID DDC sample and its strobe
//   RD_REQ               pop request
//   I_OUT, Q_OUT         last popped pair (holds between pops)
//   OUT_VALID            one-cycle pulse when I_OUT/Q_OUT update
//   LEVEL                entry count 0..2**DEPTH_LOG2
//   OVERFLOW, UNDERFLOW  sticky status flags
//   FLAG_CLEAR           clears both flags; a same-cycle event wins
module rx_iq_fifo #(
  parameter int DEPTH_LOG2  = 4,
  parameter int PRIME_LEVEL = 4
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic [15:0]           I_IN,
  input  logic [15:0]           Q_IN,
  input  logic                  IQ_VALID,
  input  logic                  RD_REQ,
  input  logic                  FLAG_CLEAR,
  output logic [15:0]           I_OUT,
  output logic [15:0]           Q_OUT,
  output logic                  OUT_VALID,
  output logic [DEPTH_LOG2:0]   LEVEL,
  output logic                  OVERFLOW,
  output logic                  UNDERFLOW
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL  = DEPTH[DEPTH_LOG2:0];
  localparam logic [DEPTH_LOG2:0] PRIME_LVL = PRIME_LEVEL[DEPTH_LOG2:0];

  typedef enum logic {S_PRIME, S_STREAM} state_e;

  state_e                state_q, state_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]   level_q, level_d;
  logic [15:0]           i_out_q, i_out_d, q_out_q, q_out_d;
  logic                  vld_q, vld_d;
  logic                  ovf_q, ovf_d, udf_q, udf_d;
  logic [31:0]           mem_q [DEPTH];

  logic full, empty, pop, rd_miss, wr_acc, wr_drop, wr_ovw, mem_we;

  always_comb begin
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    pop     = RD_REQ && (state_q == S_STREAM) && !empty;
    rd_miss = RD_REQ && !pop;
    // A pop in the same cycle frees a slot, so a write to a full buffer is still accepted.
    wr_acc  = IQ_VALID && (!full || pop);
    wr_drop = IQ_VALID && full && !pop;
`ifdef RX_FIFO_OVERWRITE_EN
    wr_ovw  = wr_drop;
`else
    wr_ovw  = 1'b0;
`endif
    mem_we  = wr_acc || wr_ovw;
  end

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(mem_we);
    // An overwrite evicts the oldest entry by advancing the read side as well.
    rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(pop || wr_ovw);
    level_d  = level_q;
    if (wr_acc && !pop)      level_d = level_q + 1'b1;
    else if (pop && !wr_acc) level_d = level_q - 1'b1;

    i_out_d = i_out_q;
    q_out_d = q_out_q;
    vld_d   = pop;
    if (pop) begin
      i_out_d = mem_q[rd_ptr_q][15:0];
      q_out_d = mem_q[rd_ptr_q][31:16];
    end

    ovf_d = wr_drop ? 1'b1 : (FLAG_CLEAR ? 1'b0 : ovf_q);
    udf_d = rd_miss ? 1'b1 : (FLAG_CLEAR ? 1'b0 : udf_q);

    case (state_q)
      S_PRIME:  if (level_q >= PRIME_LVL) state_d = S_STREAM;
      S_STREAM: if (RD_REQ && empty)      state_d = S_PRIME;
      default:  state_d = S_PRIME;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q  <= S_PRIME;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      i_out_q  <= '0;
      q_out_q  <= '0;
      vld_q    <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      i_out_q  <= i_out_d;
      q_out_q  <= q_out_d;
      vld_q    <= vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage needs no reset: the pointers and level define which entries are valid.
  always_ff @(posedge clk_in) begin
    if (mem_we) mem_q[wr_ptr_q] <= {Q_IN, I_IN};
  end

  assign I_OUT     = i_out_q;
  assign Q_OUT     = q_out_q;
  assign OUT_VALID = vld_q;
  assign LEVEL     = level_q;
  assign OVERFLOW  = ovf_q;
  assign UNDERFLOW = udf_q;

endmodule
